// File: rtl/sca_blk_pool.sv
// SCA block manager: free-block bitmap, LCT FIFO awaiting the L1A decision, and a handshaked readout queue.
// Build macro SCA_OVERWRITE_EN: an LCT with the pool empty reuses WR_BLK and marks the entry sf=1.
module sca_blk_pool #(
  parameter int NBLK      = 16,
  parameter int LCT_DEPTH = 16,
  parameter int L1A_DEPTH = 8,
  localparam int AW = $clog2(NBLK),
  localparam int LW = $clog2(LCT_DEPTH) + 1,
  localparam int QW = $clog2(L1A_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LCT,
  input  logic          L1A_VALID,
  input  logic          L1A_MATCH,
  input  logic          RD_ACK,
  input  logic          RD_DONE,
  input  logic [AW-1:0] RD_DONE_BLK,
  output logic [AW-1:0] WR_BLK,
  output logic          WR_STRB,
  output logic          RD_VALID,
  output logic [AW-1:0] RD_BLK,
  output logic          RD_SCAFULL,
  output logic          SCAFULL,
  output logic [AW:0]   NFREE,
  output logic [LW-1:0] NLCT,
  output logic [QW-1:0] NL1A,
  output logic          NOLCT,
  output logic          LCT_FULL_ERR,
  output logic          L1A_FULL_ERR,
  output logic [15:0]   ERR_WORD
);

  localparam int LPW = LW - 1;
  localparam int QPW = QW - 1;
  localparam int NW  = AW + 1;

  typedef struct packed {
    logic [AW-1:0] blk;
    logic          sf;
  } entry_t;

  entry_t          lct_mem [LCT_DEPTH];
  entry_t          rq_mem  [L1A_DEPTH];
  logic [NBLK-1:0] free_map, free_n, alloc_mask, rel_mask;
  logic [LPW-1:0]  lct_wr, lct_rd;
  logic [QPW-1:0]  rq_wr, rq_rd, rq_rd_n;
  logic [LW-1:0]   nlct_n;
  logic [QW-1:0]   nl1a_n, rq_left;
  logic [NW-1:0]   nfree_n;
  logic [AW-1:0]   alloc_idx;
  logic [15:0]     err_n;
  entry_t          push_entry, lct_head, rd_head_n;
  logic            alloc_any, lct_pop, lct_full_eff, lct_ok, lct_alloc, lct_push;
  logic            rq_pop, rq_push, rq_full_eff, rel_l1a, lct_err_n, l1a_err_n;

  function automatic logic [3:0] sat4(input logic [15:0] v);
    return (v > 16'd15) ? 4'hF : v[3:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // Lowest-index free block, taken from the bitmap as it stood before this cycle's releases.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alloc_any = 1'b0;
    alloc_idx = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (free_map[i]) begin
        alloc_any = 1'b1;
        alloc_idx = AW'(i);
      end
    end
  end

  assign lct_head     = lct_mem[lct_rd];
  assign lct_pop      = L1A_VALID && (NLCT != '0);
  assign rq_pop       = RD_ACK && RD_VALID;
  assign lct_full_eff = (NLCT == LW'(LCT_DEPTH)) && !lct_pop;
  assign rq_full_eff  = (NL1A == QW'(L1A_DEPTH)) && !rq_pop;
  assign lct_ok       = LCT && !lct_full_eff;
  assign lct_alloc    = lct_ok && alloc_any;
  assign rq_push      = lct_pop && L1A_MATCH && !rq_full_eff;
  assign rel_l1a      = lct_pop && !rq_push && !lct_head.sf;

`ifdef SCA_OVERWRITE_EN
  assign lct_push       = lct_ok;
  assign push_entry.blk = alloc_any ? alloc_idx : WR_BLK;
  assign push_entry.sf  = !alloc_any;
`else
  assign lct_push       = lct_alloc;
  assign push_entry.blk = alloc_idx;
  assign push_entry.sf  = 1'b0;
`endif

  // Releases of an already-free block are harmless ORs; the count is recomputed from the bitmap.
  always_comb begin
    alloc_mask = '0;
    rel_mask   = '0;
    if (lct_alloc) alloc_mask[alloc_idx] = 1'b1;
    if (rel_l1a)   rel_mask[lct_head.blk] = 1'b1;
    if (RD_DONE)   rel_mask[RD_DONE_BLK] = 1'b1;
    free_n  = (free_map | rel_mask) & ~alloc_mask;
    nfree_n = '0;
    for (int i = 0; i < NBLK; i++) nfree_n = nfree_n + NW'(free_n[i]);
  end

  assign nlct_n  = NLCT + LW'(lct_push) - LW'(lct_pop);
  assign nl1a_n  = NL1A + QW'(rq_push) - QW'(rq_pop);
  assign rq_left = NL1A - QW'(rq_pop);
  assign rq_rd_n = rq_rd + QPW'(rq_pop);
  // First-word-fall-through head: an empty queue shows the entry being pushed this cycle.
  assign rd_head_n = (rq_left == '0) ? lct_head : rq_mem[rq_rd_n];

  assign lct_err_n = LCT_FULL_ERR || (LCT && lct_full_eff);
  assign l1a_err_n = L1A_FULL_ERR || (lct_pop && L1A_MATCH && rq_full_eff);

  always_comb begin
    err_n = 16'h0000;
    if (lct_err_n)
      err_n = {4'hB, 3'b100, l1a_err_n, sat4(16'(nlct_n)), sat4(16'(nfree_n))};
    else if (l1a_err_n)
      err_n = {4'hB, 3'b010, 1'b0, sat8(16'(nl1a_n))};
  end

  // NOTE: storage arrays carry no reset; the pointers and counts decide which words are meaningful.
  always_ff @(posedge CLK) begin
    if (lct_push) lct_mem[lct_wr] <= push_entry;
    if (rq_push)  rq_mem[rq_wr]   <= lct_head;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      free_map     <= '1;
      NFREE        <= NW'(NBLK);
      SCAFULL      <= 1'b0;
      WR_BLK       <= '0;
      WR_STRB      <= 1'b0;
      lct_wr       <= '0;
      lct_rd       <= '0;
      NLCT         <= '0;
      rq_wr        <= '0;
      rq_rd        <= '0;
      NL1A         <= '0;
      RD_VALID     <= 1'b0;
      RD_BLK       <= '0;
      RD_SCAFULL   <= 1'b0;
      NOLCT        <= 1'b0;
      LCT_FULL_ERR <= 1'b0;
      L1A_FULL_ERR <= 1'b0;
      ERR_WORD     <= 16'h0000;
    end else begin
      free_map     <= free_n;
      NFREE        <= nfree_n;
      SCAFULL      <= (nfree_n == '0);
      WR_STRB      <= lct_push;
      if (lct_push) begin
        WR_BLK <= push_entry.blk;
        lct_wr <= lct_wr + LPW'(1);
      end
      if (lct_pop) lct_rd <= lct_rd + LPW'(1);
      NLCT         <= nlct_n;
      if (rq_push) rq_wr <= rq_wr + QPW'(1);
      rq_rd        <= rq_rd_n;
      NL1A         <= nl1a_n;
      RD_VALID     <= (nl1a_n != '0);
      RD_BLK       <= rd_head_n.blk;
      RD_SCAFULL   <= rd_head_n.sf;
      NOLCT        <= L1A_VALID && (NLCT == '0);
      LCT_FULL_ERR <= lct_err_n;
      L1A_FULL_ERR <= l1a_err_n;
      ERR_WORD     <= err_n;
    end
  end

endmodule

// File: tb/tb_sca_blk_pool.sv
// Self-checking bench for sca_blk_pool: default, LCT_DEPTH=4 and LCT_DEPTH=32 instances share one stimulus.
module tb_sca_blk_pool;

  logic       clk = 1'b0;
  logic       rst, lct, l1a_v, l1a_m, rd_ack, rd_done;
  logic [3:0] rd_done_blk;

  logic [3:0] m_wr_blk, m_rd_blk;
  logic       m_wr_strb, m_rd_valid, m_rd_sf, m_scafull, m_nolct, m_lct_err, m_l1a_err;
  logic [4:0] m_nfree, m_nlct;
  logic [3:0] m_nl1a;
  logic [15:0] m_err_word;

  logic [3:0] f_wr_blk, f_rd_blk;
  logic       f_wr_strb, f_rd_valid, f_rd_sf, f_scafull, f_nolct, f_lct_err, f_l1a_err;
  logic [4:0] f_nfree;
  logic [2:0] f_nlct;
  logic [3:0] f_nl1a;
  logic [15:0] f_err_word;

  logic [3:0] w_wr_blk, w_rd_blk;
  logic       w_wr_strb, w_rd_valid, w_rd_sf, w_scafull, w_nolct, w_lct_err, w_l1a_err;
  logic [4:0] w_nfree;
  logic [5:0] w_nlct;
  logic [3:0] w_nl1a;
  logic [15:0] w_err_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sca_blk_pool u_main (
    .CLK(clk), .RST(rst), .LCT(lct), .L1A_VALID(l1a_v), .L1A_MATCH(l1a_m), .RD_ACK(rd_ack),
    .RD_DONE(rd_done), .RD_DONE_BLK(rd_done_blk), .WR_BLK(m_wr_blk), .WR_STRB(m_wr_strb),
    .RD_VALID(m_rd_valid), .RD_BLK(m_rd_blk), .RD_SCAFULL(m_rd_sf), .SCAFULL(m_scafull),
    .NFREE(m_nfree), .NLCT(m_nlct), .NL1A(m_nl1a), .NOLCT(m_nolct), .LCT_FULL_ERR(m_lct_err),
    .L1A_FULL_ERR(m_l1a_err), .ERR_WORD(m_err_word)
  );

  sca_blk_pool #(.LCT_DEPTH(4)) u_d4 (
    .CLK(clk), .RST(rst), .LCT(lct), .L1A_VALID(l1a_v), .L1A_MATCH(l1a_m), .RD_ACK(rd_ack),
    .RD_DONE(rd_done), .RD_DONE_BLK(rd_done_blk), .WR_BLK(f_wr_blk), .WR_STRB(f_wr_strb),
    .RD_VALID(f_rd_valid), .RD_BLK(f_rd_blk), .RD_SCAFULL(f_rd_sf), .SCAFULL(f_scafull),
    .NFREE(f_nfree), .NLCT(f_nlct), .NL1A(f_nl1a), .NOLCT(f_nolct), .LCT_FULL_ERR(f_lct_err),
    .L1A_FULL_ERR(f_l1a_err), .ERR_WORD(f_err_word)
  );

  sca_blk_pool #(.LCT_DEPTH(32)) u_d32 (
    .CLK(clk), .RST(rst), .LCT(lct), .L1A_VALID(l1a_v), .L1A_MATCH(l1a_m), .RD_ACK(rd_ack),
    .RD_DONE(rd_done), .RD_DONE_BLK(rd_done_blk), .WR_BLK(w_wr_blk), .WR_STRB(w_wr_strb),
    .RD_VALID(w_rd_valid), .RD_BLK(w_rd_blk), .RD_SCAFULL(w_rd_sf), .SCAFULL(w_scafull),
    .NFREE(w_nfree), .NLCT(w_nlct), .NL1A(w_nl1a), .NOLCT(w_nolct), .LCT_FULL_ERR(w_lct_err),
    .L1A_FULL_ERR(w_l1a_err), .ERR_WORD(w_err_word)
  );

  typedef struct {
    int lct, l1a, match, ack, done, done_blk;
    int e_wr_blk, e_strb, e_nfree, e_nlct, e_nl1a, e_rv, e_nolct;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];
  int   lct_model[$];
  int   sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lct = 1'b0; l1a_v = 1'b0; l1a_m = 1'b0; rd_ack = 1'b0; rd_done = 1'b0; rd_done_blk = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic lcts(input int n);
    for (int i = 0; i < n; i++) begin
      lct = 1'b1;
      tick();
      lct = 1'b0;
    end
  endtask

  task automatic l1as(input int n, input logic m);
    for (int i = 0; i < n; i++) begin
      l1a_v = 1'b1; l1a_m = m;
      tick();
      l1a_v = 1'b0; l1a_m = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   b;
    vec_t v;
    //            lct l1a m ack dn dblk  wrb strb nfree nlct nl1a rv nolct
    vec[0]  = '{1, 0, 0, 0, 0, 0,   0, 1, 15, 1, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0,   0, 0, 15, 1, 0, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 0,   0, 0, 15, 1, 0, 0, 0};
    vec[3]  = '{1, 0, 0, 0, 0, 0,   1, 1, 14, 2, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0,   1, 0, 14, 2, 0, 0, 0};
    vec[5]  = '{0, 0, 0, 0, 0, 0,   1, 0, 14, 2, 0, 0, 0};
    vec[6]  = '{1, 0, 0, 0, 0, 0,   2, 1, 13, 3, 0, 0, 0};
    vec[7]  = '{0, 0, 0, 0, 0, 0,   2, 0, 13, 3, 0, 0, 0};
    vec[8]  = '{0, 1, 1, 0, 0, 0,   2, 0, 13, 2, 1, 1, 0};
    vec[9]  = '{0, 1, 0, 0, 0, 0,   2, 0, 14, 1, 1, 1, 0};
    vec[10] = '{0, 1, 1, 0, 0, 0,   2, 0, 14, 0, 2, 1, 0};
    vec[11] = '{0, 0, 0, 1, 0, 0,   2, 0, 14, 0, 1, 1, 0};
    vec[12] = '{0, 0, 0, 1, 0, 0,   2, 0, 14, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 1, 0,   2, 0, 15, 0, 0, 0, 0};
    vec[14] = '{0, 0, 0, 0, 1, 2,   2, 0, 16, 0, 0, 0, 0};
    vec[15] = '{0, 0, 0, 0, 1, 2,   2, 0, 16, 0, 0, 0, 0};
    vec[16] = '{1, 0, 0, 0, 0, 0,   0, 1, 15, 1, 0, 0, 0};
    vec[17] = '{1, 0, 0, 0, 0, 0,   1, 1, 14, 2, 0, 0, 0};
    vec[18] = '{0, 1, 1, 0, 0, 0,   1, 0, 14, 1, 1, 1, 0};
    vec[19] = '{0, 1, 0, 1, 1, 0,   1, 0, 16, 0, 0, 0, 0};
    vec[20] = '{0, 1, 0, 0, 0, 0,   1, 0, 16, 0, 0, 0, 1};
    vec[21] = '{1, 1, 0, 0, 0, 0,   0, 1, 15, 1, 0, 0, 1};
    vec[22] = '{0, 0, 0, 0, 0, 0,   0, 0, 15, 1, 0, 0, 0};
    vec[23] = '{0, 0, 0, 1, 0, 0,   0, 0, 15, 1, 0, 0, 0};

    do_reset();
    check("rst.nfree", m_nfree, 16);
    check("rst.wr_blk", m_wr_blk, 0);
    check("rst.nlct", m_nlct, 0);
    check("rst.nl1a", m_nl1a, 0);
    check("rst.flags", {m_wr_strb, m_rd_valid, m_rd_sf, m_nolct, m_scafull, m_lct_err, m_l1a_err}, 0);
    check("rst.err_word", m_err_word, 0);

    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      lct = (v.lct != 0); l1a_v = (v.l1a != 0); l1a_m = (v.match != 0);
      rd_ack = (v.ack != 0); rd_done = (v.done != 0); rd_done_blk = 4'(v.done_blk);
      if (v.l1a != 0 && lct_model.size() > 0) begin
        b = lct_model.pop_front();
        if (v.match != 0) sb.push_back(b);
      end
      if (v.ack != 0 && sb.size() > 0) begin
        b = sb.pop_front();
        check($sformatf("v%0d.rd_blk", i), m_rd_blk, b);
      end
      tick();
      idle_inputs();
      if (v.e_strb != 0) lct_model.push_back(v.e_wr_blk);
      check($sformatf("v%0d.wr_blk", i), m_wr_blk, v.e_wr_blk);
      check($sformatf("v%0d.wr_strb", i), m_wr_strb, v.e_strb);
      check($sformatf("v%0d.nfree", i), m_nfree, v.e_nfree);
      check($sformatf("v%0d.nlct", i), m_nlct, v.e_nlct);
      check($sformatf("v%0d.nl1a", i), m_nl1a, v.e_nl1a);
      check($sformatf("v%0d.rd_valid", i), m_rd_valid, v.e_rv);
      check($sformatf("v%0d.nolct", i), m_nolct, v.e_nolct);
      check($sformatf("v%0d.scafull", i), m_scafull, (v.e_nfree == 0));
    end

    // Readout queue fill, legal push-on-full with a same-cycle pop, then overflow.
    do_reset();
    lcts(10);
    l1as(8, 1'b1);
    check("rq.full_nl1a", m_nl1a, 8);
    check("rq.no_err_yet", m_l1a_err, 0);
    l1a_v = 1'b1; l1a_m = 1'b1; rd_ack = 1'b1;
    tick();
    idle_inputs();
    check("rq.pushpop_nl1a", m_nl1a, 8);
    check("rq.pushpop_err", m_l1a_err, 0);
    check("rq.pushpop_head", m_rd_blk, 1);
    l1as(1, 1'b1);
    check("rq.ovf_err", m_l1a_err, 1);
    check("rq.ovf_nfree", m_nfree, 7);
    check("rq.ovf_nlct", m_nlct, 0);
    check("rq.ovf_word", m_err_word, 16'hB408);
    rd_ack = 1'b1;
    tick();
    idle_inputs();
    check("rq.sticky_err", m_l1a_err, 1);
    check("rq.sticky_word", m_err_word, 16'hB407);

    // LCT FIFO overflow on the 4-deep instance, then push-on-full with a same-cycle pop.
    do_reset();
    lcts(4);
    check("d4.no_err_yet", f_lct_err, 0);
    lcts(1);
    check("d4.lct_err", f_lct_err, 1);
    check("d4.nlct", f_nlct, 4);
    check("d4.nfree", f_nfree, 12);
    check("d4.err_word", f_err_word, 16'hB84C);
    lct = 1'b1; l1a_v = 1'b1; l1a_m = 1'b0;
    tick();
    idle_inputs();
    check("d4.pushpop_nlct", f_nlct, 4);
    check("d4.pushpop_wr_blk", f_wr_blk, 4);
    check("d4.pushpop_strb", f_wr_strb, 1);
    check("d4.pushpop_nfree", f_nfree, 12);
    check("d4.pushpop_word", f_err_word, 16'hB84C);

    // Pool exhaustion on the 32-deep instance.
    do_reset();
    lcts(17);
    check("d32.scafull", w_scafull, 1);
    check("d32.nfree", w_nfree, 0);
    check("d32.wr_blk", w_wr_blk, 15);
`ifdef SCA_OVERWRITE_EN
    check("d32.strb17", w_wr_strb, 1);
    check("d32.nlct", w_nlct, 17);
`else
    check("d32.strb17", w_wr_strb, 0);
    check("d32.nlct", w_nlct, 16);
`endif
    l1as(16, 1'b0);
    check("d32.nfree_after", w_nfree, 16);
`ifdef SCA_OVERWRITE_EN
    l1as(1, 1'b1);
    check("d32.ovr_valid", w_rd_valid, 1);
    check("d32.ovr_blk", w_rd_blk, 15);
    check("d32.ovr_sf", w_rd_sf, 1);
    check("d32.ovr_nfree", w_nfree, 16);
`else
    check("d32.nlct_after", w_nlct, 0);
    l1as(1, 1'b1);
    check("d32.nolct", w_nolct, 1);
    check("d32.rd_valid", w_rd_valid, 0);
`endif

    // Reset in the middle of traffic.
    do_reset();
    lcts(5);
    l1as(2, 1'b1);
    check("mid.nlct", m_nlct, 3);
    check("mid.nl1a", m_nl1a, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.nfree", m_nfree, 16);
    check("mid.nlct0", m_nlct, 0);
    check("mid.nl1a0", m_nl1a, 0);
    check("mid.rd_valid", m_rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
